idli_slice_rx_m: RTL and testbench



---
 rtl/idli_pkg.sv | 15 +
 rtl/idli_slice_rx_m.sv | 110 +++++++++++
 tb/tb_idli_slice_rx_m.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Shared widths and types for the idli nibble-serial datapath.
package idli_pkg;

  typedef logic [3:0]  slice_t;
  typedef logic [1:0]  ctr_t;
  typedef logic [15:0] word_t;

  // Slice-receiver collector states, kept as plain constants so older
  // blocks that compare against raw codes still line up.
  typedef logic [1:0] srx_state_t;
  localparam srx_state_t SRX_IDLE    = 2'd0;
  localparam srx_state_t SRX_COLLECT = 2'd1;
  localparam srx_state_t SRX_FULL    = 2'd2;

endpackage

// File: rtl/idli_slice_rx_m.sv
// Gathers four LSB-first nibble slices into a 16-bit word and presents it
// to a parallel consumer through a one-word valid/ready holding stage.
module idli_slice_rx_m
  import idli_pkg::*;
(
  input  logic        i_srx_gck,
  input  logic        i_srx_rst,
  input  logic        i_srx_vld,
  input  logic [1:0]  i_srx_ctr,
  input  logic [3:0]  i_srx_in,
  output logic        o_srx_stall,
  output logic        o_srx_vld,
  input  logic        i_srx_rdy,
  output logic [15:0] o_srx_data,
  output logic        o_srx_err,
  input  logic        i_srx_clr
);

  srx_state_t state;
  ctr_t       nxt_ctr;
  word_t      collector;
  logic       hold_vld;
  word_t      hold_data;
  logic       err;

  ctr_t  exp_ctr;
  logic  drain;
  logic  seq_hit;
  logic  err_set;
  word_t done_word;

  always_comb begin
    exp_ctr   = (state == SRX_IDLE) ? 2'd0 : nxt_ctr;
    drain     = hold_vld & i_srx_rdy;
    seq_hit   = i_srx_vld & (i_srx_ctr == exp_ctr);
    // Any slice arriving while FULL is an overflow; otherwise a wrong index.
    err_set   = i_srx_vld & ((state == SRX_FULL) | (i_srx_ctr != exp_ctr));
    done_word = {i_srx_in, collector[11:0]};
  end

  // NOTE: all state updates use non-blocking assignments; later assignments
  // in the same block override earlier defaults, which the drain logic uses.
  always_ff @(posedge i_srx_gck) begin
    if (i_srx_rst) begin
      state     <= SRX_IDLE;
      nxt_ctr   <= 2'd0;
      collector <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
      err       <= 1'b0;
    end else begin
      err <= err_set | (err & ~i_srx_clr);

      if (drain)
        hold_vld <= 1'b0;

      case (state)
        SRX_IDLE, SRX_COLLECT: begin
          if (seq_hit) begin
            if (i_srx_ctr == 2'd3) begin
              if (!hold_vld || drain) begin
                hold_data <= done_word;
                hold_vld  <= 1'b1;
                collector <= '0;
                state     <= SRX_IDLE;
              end else begin
                collector <= done_word;
                state     <= SRX_FULL;
              end
            end else begin
              collector[{i_srx_ctr, 2'b00} +: 4] <= i_srx_in;
              nxt_ctr <= i_srx_ctr + 2'd1;
              state   <= SRX_COLLECT;
            end
          end else if (i_srx_vld) begin
            // Out-of-order slice: a fresh index 0 restarts, anything else aborts.
            if (i_srx_ctr == 2'd0) begin
              collector <= {12'h000, i_srx_in};
              nxt_ctr   <= 2'd1;
              state     <= SRX_COLLECT;
            end else begin
              collector <= '0;
              state     <= SRX_IDLE;
            end
          end
        end

        SRX_FULL: begin
          if (drain) begin
            hold_data <= collector;
            hold_vld  <= 1'b1;
            collector <= '0;
            state     <= SRX_IDLE;
          end
        end

        default: begin
          collector <= '0;
          state     <= SRX_IDLE;
        end
      endcase
    end
  end

  assign o_srx_stall = (state == SRX_FULL);
  assign o_srx_vld   = hold_vld;
  assign o_srx_data  = hold_data;
  assign o_srx_err   = err;

endmodule

// File: tb/tb_idli_slice_rx_m.sv
// Directed self-checking bench for idli_slice_rx_m.
module tb_idli_slice_rx_m;

  logic        gck = 1'b0;
  logic        rst, vld, rdy, clr;
  logic [1:0]  ctr;
  logic [3:0]  din;
  logic        stall, ovld, err;
  logic [15:0] data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 gck = ~gck;

  idli_slice_rx_m dut (
    .i_srx_gck  (gck),
    .i_srx_rst  (rst),
    .i_srx_vld  (vld),
    .i_srx_ctr  (ctr),
    .i_srx_in   (din),
    .o_srx_stall(stall),
    .o_srx_vld  (ovld),
    .i_srx_rdy  (rdy),
    .o_srx_data (data),
    .o_srx_err  (err),
    .i_srx_clr  (clr)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gck);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [3:0] d);
    vld = 1'b1;
    ctr = c;
    din = d;
    tick();
    vld = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] tmp;
      tmp = w >> (4 * i);
      send(2'(i), tmp[3:0]);
    end
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; rdy = 1'b1; clr = 1'b0; ctr = '0; din = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_vld",   {15'd0, ovld},  16'd0);
    check("rst_stall", {15'd0, stall}, 16'd0);
    check("rst_err",   {15'd0, err},   16'd0);
    check("rst_data",  data,           16'h0000);

    // Basic assembly, LSB slice first.
    send(2'd0, 4'h4);
    send(2'd1, 4'h3);
    send(2'd2, 4'h2);
    check("basic_vld_early", {15'd0, ovld}, 16'd0);
    send(2'd3, 4'h1);
    check("basic_vld",  {15'd0, ovld}, 16'd1);
    check("basic_data", data,          16'h1234);
    check("basic_err",  {15'd0, err},  16'd0);
    tick();
    check("basic_drained", {15'd0, ovld}, 16'd0);

    // Back-pressure: second word parks in the collector.
    rdy = 1'b0;
    send_word(16'hBEEF);
    check("bp_first_vld", {15'd0, ovld}, 16'd1);
    send_word(16'h0F0F);
    check("bp_hold_data", data,           16'hBEEF);
    check("bp_stall",     {15'd0, stall}, 16'd1);
    rdy = 1'b1;
    tick();
    check("bp_second_data",  data,           16'h0F0F);
    check("bp_second_vld",   {15'd0, ovld},  16'd1);
    check("bp_stall_clear",  {15'd0, stall}, 16'd0);
    tick();
    check("bp_empty", {15'd0, ovld}, 16'd0);

    // Sequence error drops the partial word.
    send(2'd0, 4'h9);
    send(2'd1, 4'h9);
    send(2'd3, 4'h9);
    check("seq_err",    {15'd0, err},  16'd1);
    check("seq_no_vld", {15'd0, ovld}, 16'd0);
    rdy = 1'b0;
    send_word(16'hA5A5);
    check("seq_next_data", data,          16'hA5A5);
    check("seq_err_stuck", {15'd0, err},  16'd1);
    rdy = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("seq_clr", {15'd0, err}, 16'd0);
    check("seq_drained", {15'd0, ovld}, 16'd0);

    // Clear coinciding with a new error: error wins.
    clr = 1'b1;
    send(2'd2, 4'h1);
    clr = 1'b0;
    check("clr_vs_err", {15'd0, err}, 16'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_after", {15'd0, err}, 16'd0);

    // Overflow while FULL.
    rdy = 1'b0;
    send_word(16'h1111);
    send_word(16'h2222);
    check("ovf_stall", {15'd0, stall}, 16'd1);
    send(2'd0, 4'h7);
    check("ovf_err",       {15'd0, err},   16'd1);
    check("ovf_stall_hold", {15'd0, stall}, 16'd1);
    check("ovf_data_hold", data,           16'h1111);
    rdy = 1'b1;
    tick();
    check("ovf_drain_data", data, 16'h2222);
    tick();
    check("ovf_drain_vld", {15'd0, ovld}, 16'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Reset mid-word discards everything.
    rdy = 1'b0;
    send(2'd0, 4'hE);
    send(2'd1, 4'hF);
    send(2'd2, 4'hA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_vld",  {15'd0, ovld}, 16'd0);
    check("rstmid_data", data,          16'h0000);
    tick();
    check("rstmid_vld_later", {15'd0, ovld}, 16'd0);
    send_word(16'h0001);
    check("rstmid_next", data,          16'h0001);
    check("rstmid_err",  {15'd0, err},  16'd0);
    rdy = 1'b1;
    tick();

    // Gaps between slices are legal.
    rdy = 1'b0;
    send(2'd0, 4'hD);
    tick(); tick(); tick();
    check("gap_no_vld", {15'd0, ovld}, 16'd0);
    send(2'd1, 4'h0);
    tick();
    send(2'd2, 4'h0);
    send(2'd3, 4'hD);
    check("gap_data", data,          16'hD00D);
    check("gap_vld",  {15'd0, ovld}, 16'd1);
    check("gap_err",  {15'd0, err},  16'd0);
    tick();
    check("gap_stable", data, 16'hD00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
